sniffer_capture_buffer: RTL
===========================

# sniffer_capture_buffer

Parametrised successor to the sniffer's fixed 5-beat data pass-through. It accepts the Avalon-ST packet stream and delays it by DELAY cycles, so the string, IP, MAC and port comparators can resolve matches. It writes each packet speculatively into a circular memory region and keeps only packets that hit at least one of NCH match channels. Per-channel hit counters and a commit-descriptor strobe feed the host-side packet logger.

## Interface
Parameters:
- DATA_W, 32, stream and memory word width (multiple of 8)
- EMPTY_W, 2, width of `empty` (log2(DATA_W/8))
- DELAY, 5, fixed pipeline delay in cycles (>=1)
- NCH, 4, number of match channels
- BUF_WORDS, 1024, circular region size in words (power of 2, >=4)
- BASE_ADDR, 0, byte address of region word 0
- HIT_W, 64, width of each hit counter

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock
  - n_rst  in  1  async active-low reset
- Input stream:
  - data_in  in  DATA_W  stream beat
  - sop  in  1  start of packet
  - eop  in  1  end of packet
  - empty  in  EMPTY_W  unused bytes on eop beat
  - error  in  6  nonzero marks beat errored
  - valid  in  1  beat present
  - ready  in  1  capture enable; beat accepted iff valid && ready
- Match and control:
  - match_in  in  NCH  per-channel comparator hit pulses
  - update_done  in  1  sync clear of counters and capture state
- Memory write port:
  - write_enable  out  1  memory write strobe
  - addr_out  out  32  byte address, BASE_ADDR + ptr*(DATA_W/8)
  - data_out  out  DATA_W  memory write data
- Commit descriptor:
  - commit_valid  out  1  one-cycle descriptor strobe
  - commit_start  out  log2(BUF_WORDS)  first word index of committed packet
  - commit_len  out  log2(BUF_WORDS)+1  committed length in words
  - commit_empty  out  EMPTY_W  empty of last word
  - commit_match  out  NCH  channels that hit
- Status and counters:
  - drop_pulse  out  1  packet discarded
  - hits  out  NCH*HIT_W  channel c at [c*HIT_W +: HIT_W]

## Operation
- Input tracker:
  - Accepted sop opens a packet and clears the match accumulator.
  - match_in is ORed into the accumulator every cycle while a packet is open, including its eop cycle.
  - Accepted beats outside an open packet (no sop) are discarded.
  - sop while already open aborts the open packet; the aborted packet drops and the new one starts.
  - Single-beat packet: sop and eop on the same beat.
- Delay line: DELAY stages shifting every cycle. Each stage holds {valid, data, sop, eop, empty, err, match}. Bubbles propagate as valid=0. Match and err are sticky and are carried on the eop stage.
- Writer FSM, at the delay-line output:
  - IDLE: a sop beat moves to WRITE; wr_ptr=start_ptr.
  - WRITE: every valid beat gives write_enable=1, data_out=beat, addr_out from wr_ptr, then wr_ptr++ (mod BUF_WORDS).
  - OVERFLOW: entered when a packet reaches BUF_WORDS words. Writes stop until eop, then the packet drops.
- Decision on the eop beat:
  - Commit iff match!=0, err=0 and no overflow. Then start_ptr advances past the packet, commit_valid pulses, and hits[c] increments for each set match bit, saturating at all-ones.
  - Otherwise wr_ptr and start_ptr stay at the packet start, drop_pulse fires, and no counter moves.
  - Either way the FSM returns to IDLE.
  - An aborted packet drops at the point where the next sop reaches the output.
- update_done clears hits, pointers, tracker and FSM to IDLE, and flushes the delay line. It takes precedence over all other events that cycle.

## Timing
- Reset value of every output is 0 and the FSM is IDLE.
- A beat accepted at edge k appears on write_enable/data_out/addr_out after edge k+DELAY.
- commit_valid / drop_pulse / hits update are registered, one cycle after the eop write.
- Commits of back-to-back packets with one idle beat between them sustain without loss.
- Reset mid-packet discards everything in flight.

## Configuration
- SNIFFER_ERR_CAPTURE_EN defined:
  - Errored packets that match are committed.
  - commit_match is still driven.
  - hits does not increment for them.
- SNIFFER_ERR_CAPTURE_EN undefined: any nonzero error drops the packet.

## Test plan
- Reset, then idle: all outputs 0, and stay 0 for 10 cycles with valid=0.
- 8-beat packet, match_in=4'b0001 on beat 3, DELAY=5:
  - write_enable on cycles k+5..k+12 at addresses BASE_ADDR+0..28.
  - commit_len=8, commit_match=0001, hits[0]=1.
- Same packet with match_in=0: 8 writes occur, then drop_pulse=1. The next packet rewrites from address BASE_ADDR+0.
- BUF_WORDS=16, three committed 6-word packets: the third starts at word 12 and wraps to word 1. A 17-word matched packet drops.
- Matched packet with error=6'h01 on beat 2: dropped by default. Committed with SNIFFER_ERR_CAPTURE_EN, with hits unchanged.
- sop, 3 beats, sop again: the first packet drops. update_done mid-packet: hits=0 and no commit.

Source files
------------

// File: rtl/sniffer_capture_buffer.sv
// sniffer_capture_buffer: delays the Avalon-ST packet stream by DELAY cycles,
// writes each packet speculatively into a circular memory region and commits it
// only when at least one match channel hit; otherwise the region is rewound.
// Ports: clk/n_rst; stream in (data_in, sop, eop, empty, error, valid, ready);
// match_in, update_done; memory write (write_enable, addr_out, data_out);
// commit descriptor (commit_*); drop_pulse; per-channel hit counters (hits).
// Optional macro SNIFFER_ERR_CAPTURE_EN: commit matching errored packets
// without counting them in hits.
module sniffer_capture_buffer #(
    parameter int          DATA_W    = 32,
    parameter int          EMPTY_W   = 2,
    parameter int          DELAY     = 5,
    parameter int          NCH       = 4,
    parameter int          BUF_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          HIT_W     = 64,
    localparam int         PTR_W     = $clog2(BUF_WORDS)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 sop,
    input  logic                 eop,
    input  logic [EMPTY_W-1:0]   empty,
    input  logic [5:0]           error,
    input  logic                 valid,
    input  logic                 ready,
    input  logic [NCH-1:0]       match_in,
    input  logic                 update_done,
    output logic                 write_enable,
    output logic [31:0]          addr_out,
    output logic [DATA_W-1:0]    data_out,
    output logic                 commit_valid,
    output logic [PTR_W-1:0]     commit_start,
    output logic [PTR_W:0]       commit_len,
    output logic [EMPTY_W-1:0]   commit_empty,
    output logic [NCH-1:0]       commit_match,
    output logic                 drop_pulse,
    output logic [NCH*HIT_W-1:0] hits
);

    localparam int             BYTES = DATA_W / 8;
    localparam logic [PTR_W:0] FULL  = (PTR_W+1)'(BUF_WORDS);

    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic               err;
        logic [NCH-1:0]     match;
    } beat_t;

    typedef enum logic [1:0] {IDLE, WRITE, OVFL} state_t;

    logic err_blocks;
`ifdef SNIFFER_ERR_CAPTURE_EN
    assign err_blocks = 1'b0;
`else
    assign err_blocks = 1'b1;
`endif

    logic accept;
    assign accept = valid && ready;

    // input tracker
    logic           open_q, open_d;
    logic [NCH-1:0] acc_q, acc_d;
    logic           err_q, err_d;
    beat_t          in_beat;

    // delay line
    beat_t stage_q [DELAY];
    beat_t stage_d [DELAY];
    beat_t out_beat;

    // writer
    state_t           st_q, st_d;
    logic [PTR_W-1:0] wr_q, wr_d, start_q, start_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    // decision taken on the eop write, published one cycle later
    logic               pc_q, pc_d, pd_q, pd_d, ph_q, ph_d;
    logic [PTR_W-1:0]   ps_q, ps_d;
    logic [PTR_W:0]     pl_q, pl_d;
    logic [EMPTY_W-1:0] pe_q, pe_d;
    logic [NCH-1:0]     pm_q, pm_d;

    logic               cv_q, cv_d, drop_q, drop_d;
    logic [PTR_W-1:0]   cs_q, cs_d;
    logic [PTR_W:0]     cl_q, cl_d;
    logic [EMPTY_W-1:0] ce_q, ce_d;
    logic [NCH-1:0]     cm_q, cm_d;
    logic [NCH*HIT_W-1:0] hits_q, hits_d;

    logic [PTR_W-1:0] wptr;
    logic [PTR_W:0]   wcnt;
    logic             ovf, active, keep;

    always_comb begin
        open_d = open_q;
        acc_d  = acc_q;
        err_d  = err_q;
        in_beat       = '0;
        in_beat.data  = data_in;
        in_beat.empty = empty;
        if (accept && sop) begin
            // a sop while open simply restarts; the writer drops the old one
            open_d = !eop;
            acc_d  = match_in;
            err_d  = |error;
            in_beat.valid = 1'b1;
            in_beat.sop   = 1'b1;
            in_beat.eop   = eop;
            in_beat.match = match_in;
            in_beat.err   = |error;
        end else if (open_q) begin
            acc_d = acc_q | match_in;
            if (accept) begin
                err_d  = err_q | (|error);
                open_d = !eop;
                in_beat.valid = 1'b1;
                in_beat.eop   = eop;
            end
            in_beat.match = acc_d;
            in_beat.err   = err_d;
        end
        if (update_done) begin
            open_d = 1'b0;
            acc_d  = '0;
            err_d  = 1'b0;
        end
    end

    always_comb begin
        stage_d[0] = in_beat;
        for (int i = 1; i < DELAY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        if (update_done) begin
            for (int i = 0; i < DELAY; i++) begin
                stage_d[i] = '0;
            end
        end
    end

    assign out_beat = stage_q[DELAY-1];

    always_comb begin
        st_d    = st_q;
        wr_d    = wr_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        dout_d  = dout_q;
        pc_d = 1'b0;
        pd_d = 1'b0;
        ph_d = ph_q;
        ps_d = ps_q;
        pl_d = pl_q;
        pe_d = pe_q;
        pm_d = pm_q;
        wptr   = wr_q;
        wcnt   = cnt_q;
        ovf    = (st_q == OVFL);
        active = 1'b0;
        keep   = 1'b0;
        if (out_beat.valid) begin
            if (out_beat.sop) begin
                // an unfinished packet still in progress is aborted here
                pd_d   = (st_q != IDLE);
                wptr   = start_q;
                wcnt   = '0;
                ovf    = 1'b0;
                active = 1'b1;
            end else begin
                active = (st_q != IDLE);
            end
        end
        if (active) begin
            if (!ovf && wcnt == FULL) begin
                ovf = 1'b1;
            end
            if (!ovf) begin
                we_d   = 1'b1;
                addr_d = BASE_ADDR + 32'(wptr) * 32'(BYTES);
                dout_d = out_beat.data;
                wptr   = wptr + 1'b1;
                wcnt   = wcnt + 1'b1;
            end
            st_d  = ovf ? OVFL : WRITE;
            wr_d  = wptr;
            cnt_d = wcnt;
            if (out_beat.eop) begin
                st_d = IDLE;
                keep = (|out_beat.match) && !ovf
                       && !(out_beat.err && err_blocks);
                if (keep) begin
                    start_d = wptr;
                    pc_d = 1'b1;
                    ps_d = start_q;
                    pl_d = wcnt;
                    pe_d = out_beat.empty;
                    pm_d = out_beat.match;
                    ph_d = !out_beat.err;
                end else begin
                    // rewind so the next packet overwrites this one
                    pd_d  = 1'b1;
                    wr_d  = start_q;
                    cnt_d = '0;
                end
            end
        end
        if (update_done) begin
            st_d    = IDLE;
            wr_d    = '0;
            start_d = '0;
            cnt_d   = '0;
            we_d    = 1'b0;
            pc_d    = 1'b0;
            pd_d    = 1'b0;
        end
    end

    always_comb begin
        cv_d   = pc_q;
        drop_d = pd_q;
        cs_d   = pc_q ? ps_q : cs_q;
        cl_d   = pc_q ? pl_q : cl_q;
        ce_d   = pc_q ? pe_q : ce_q;
        cm_d   = pc_q ? pm_q : cm_q;
        hits_d = hits_q;
        if (pc_q && ph_q) begin
            for (int c = 0; c < NCH; c++) begin
                if (pm_q[c] && hits_q[c*HIT_W +: HIT_W] != {HIT_W{1'b1}}) begin
                    hits_d[c*HIT_W +: HIT_W] =
                        hits_q[c*HIT_W +: HIT_W] + HIT_W'(1);
                end
            end
        end
        if (update_done) begin
            cv_d   = 1'b0;
            drop_d = 1'b0;
            hits_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            open_q <= 1'b0;
            acc_q  <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < DELAY; i++) begin
                stage_q[i] <= '0;
            end
            st_q    <= IDLE;
            wr_q    <= '0;
            start_q <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            pc_q <= 1'b0;
            pd_q <= 1'b0;
            ph_q <= 1'b0;
            ps_q <= '0;
            pl_q <= '0;
            pe_q <= '0;
            pm_q <= '0;
            cv_q   <= 1'b0;
            drop_q <= 1'b0;
            cs_q   <= '0;
            cl_q   <= '0;
            ce_q   <= '0;
            cm_q   <= '0;
            hits_q <= '0;
        end else begin
            open_q <= open_d;
            acc_q  <= acc_d;
            err_q  <= err_d;
            for (int i = 0; i < DELAY; i++) begin
                stage_q[i] <= stage_d[i];
            end
            st_q    <= st_d;
            wr_q    <= wr_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            pc_q <= pc_d;
            pd_q <= pd_d;
            ph_q <= ph_d;
            ps_q <= ps_d;
            pl_q <= pl_d;
            pe_q <= pe_d;
            pm_q <= pm_d;
            cv_q   <= cv_d;
            drop_q <= drop_d;
            cs_q   <= cs_d;
            cl_q   <= cl_d;
            ce_q   <= ce_d;
            cm_q   <= cm_d;
            hits_q <= hits_d;
        end
    end

    assign write_enable = we_q;
    assign addr_out     = addr_q;
    assign data_out     = dout_q;
    assign commit_valid = cv_q;
    assign commit_start = cs_q;
    assign commit_len   = cl_q;
    assign commit_empty = ce_q;
    assign commit_match = cm_q;
    assign drop_pulse   = drop_q;
    assign hits         = hits_q;

endmodule
